// File: rtl/dct_pkg.sv
// dct_pkg: shared types and default geometry for the DCT front-end block loader
package dct_pkg;
  typedef enum logic {IDLE, FETCH} fetch_state_t;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;
  localparam int DEF_PIX = DEF_ROWS * DEF_COLS;
  typedef logic [DEF_ROWS-1:0][DEF_COLS-1:0][DEF_DATA_W-1:0] block_t;
endpackage

// File: rtl/block_bank.sv
// block_bank: ROWS x COLS register array, one write port, sync reset to RESET_VAL
module block_bank
  import dct_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int RESET_VAL = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic we,
  input  logic [$clog2(ROWS*COLS)-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] block
);
  logic [ROWS*COLS-1:0][DATA_W-1:0] mem;
  always_ff @(posedge clock) begin
    if (reset) mem <= {(ROWS*COLS){DATA_W'(RESET_VAL)}};
    else if (we) mem[idx] <= wdata;
  end
  // flat row-major storage has the same bit layout as the 2-D view
  assign block = mem;
endmodule

// File: rtl/block_fetch_pingpong.sv
// block_fetch_pingpong: fetches ROWS x COLS blocks into two ping-pong banks with valid/ready output
module block_fetch_pingpong
  import dct_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter int NUM_BLOCKS = 32,
  parameter int RESET_VAL = 1,
  parameter int ADDR_W = $clog2(NUM_BLOCKS*ROWS*COLS)
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  input  logic [31:0] req_block,
  output logic mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic out_valid,
  input  logic out_ready,
  output logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] out_block,
  output logic [$clog2(NUM_BLOCKS)-1:0] out_index,
  output logic busy
);
  localparam int PIX = ROWS * COLS;
  localparam int KW = $clog2(PIX);
  localparam int BW = $clog2(NUM_BLOCKS);
  fetch_state_t state;
  logic [KW:0] cnt;
  logic [ADDR_W-1:0] base;
  logic [BW-1:0] cur_idx, req_idx;
  logic [BW-1:0] idx [2];
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] blk [2];
  logic [KW-1:0] cap_k;
  logic [1:0] full, full_kept;
  logic wbank, head, cap_v, accept, issue, done, pop;
  assign req_idx = BW'(req_block % 32'(NUM_BLOCKS));
  assign req_ready = !reset && state == IDLE && !(&full);
  assign accept = req_valid && req_ready;
  // the acceptance cycle already issues element 0, so element k lands one edge after it is addressed
  assign issue = !reset && state == FETCH && cnt < (KW+1)'(PIX);
  assign mem_rd_en = accept || issue;
  assign mem_rd_addr = accept ? ADDR_W'(req_idx) * ADDR_W'(PIX) : issue ? base + ADDR_W'(cnt) : '0;
  assign done = cap_v && cap_k == KW'(PIX-1);
  assign out_valid = full[head];
  assign pop = out_valid && out_ready;
  assign full_kept = {full[1] && !(pop && head), full[0] && !(pop && !head)};
  assign out_block = blk[head];
  assign out_index = idx[head];
  assign busy = state == FETCH || (|full);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      base <= '0;
      cur_idx <= '0;
      wbank <= 1'b0;
      head <= 1'b0;
      cap_v <= 1'b0;
      cap_k <= '0;
      full <= '0;
      idx[0] <= '0;
      idx[1] <= '0;
    end else begin
      cap_v <= mem_rd_en;
      cap_k <= accept ? '0 : KW'(cnt);
      if (accept) begin
        state <= FETCH;
        cnt <= (KW+1)'(1);
        base <= mem_rd_addr;
        cur_idx <= req_idx;
        wbank <= full[0];
      end else if (issue) cnt <= cnt + 1'b1;
      if (done) begin
        state <= IDLE;
        idx[wbank] <= cur_idx;
      end
      full <= full_kept | (done ? 2'b01 << wbank : 2'b00);
      // a bank completing into an otherwise empty pair becomes the head
      head <= (done && !full_kept[!wbank]) ? wbank : head ^ pop;
    end
  end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    block_bank #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .RESET_VAL(RESET_VAL)) u_bank (
      .clock(clock),
      .reset(reset),
      .we(cap_v && wbank == 1'(b)),
      .idx(cap_k),
      .wdata(mem_rd_data),
      .block(blk[b])
    );
  end
endmodule

// File: tb/tb_block_fetch_pingpong.sv
// tb_block_fetch_pingpong: table, directed and random checks against a queue-based model
module tb_block_fetch_pingpong;
  localparam int DATA_W = 32, ROWS = 8, COLS = 8, NUM_BLOCKS = 32, PIX = ROWS * COLS;
  localparam int ADDR_W = $clog2(NUM_BLOCKS * PIX), BW = $clog2(NUM_BLOCKS);
  logic clock = 0, reset = 1, req_valid = 0, out_ready = 0;
  logic [31:0] req_block = 0;
  logic req_ready, mem_rd_en, out_valid, busy;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data = 0;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] out_block;
  logic [BW-1:0] out_index;
  int checks = 0, failures = 0;
  int q[$];
  bit fetching = 0;
  int t = 0, cur = 0;
  typedef struct {logic [31:0] blk; int idx; int b00; int b77;} vec_t;
  vec_t vec[7];

  always #5 clock = ~clock;
  // frame buffer: word i holds i+100, one-cycle read latency
  always @(posedge clock) if (mem_rd_en) mem_rd_data <= DATA_W'(mem_rd_addr) + DATA_W'(100);

  block_fetch_pingpong #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .NUM_BLOCKS(NUM_BLOCKS), .RESET_VAL(1)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_block(req_block),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block), .out_index(out_index), .busy(busy)
  );

  task automatic check(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int base_of(logic [31:0] b);
    return int'(b % NUM_BLOCKS) * PIX;
  endfunction

  function automatic int blk_err(int id);
    int e = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (out_block[r][c] !== DATA_W'(id * PIX + r * COLS + c + 100)) e++;
    return e;
  endfunction

  // model: a FIFO of filled block numbers plus a countdown for the block in flight
  task automatic cycle(output bit acc);
    bit rdy, iss, pop;
    int ea;
    rdy = !fetching && q.size() < 2;
    acc = req_valid && rdy;
    iss = fetching && t >= 2;
    ea = acc ? base_of(req_block) : iss ? cur * PIX + PIX - t + 1 : 0;
    #1;
    check("req_ready", req_ready, rdy);
    check("mem_rd_en", mem_rd_en, acc || iss);
    check("mem_rd_addr", mem_rd_addr, ea);
    check("out_valid", out_valid, q.size() > 0);
    check("busy", busy, fetching || q.size() > 0);
    if (q.size() > 0) begin
      check("out_index", out_index, q[0]);
      check("out_block_errors", blk_err(q[0]), 0);
    end
    pop = q.size() > 0 && out_ready;
    @(posedge clock);
    if (pop) void'(q.pop_front());
    if (fetching) begin
      t--;
      if (t == 0) begin
        q.push_back(cur);
        fetching = 0;
      end
    end
    if (acc) begin
      fetching = 1;
      t = PIX;
      cur = int'(req_block % NUM_BLOCKS);
    end
    @(negedge clock);
  endtask

  initial begin
    bit acc;
    int n, bad;
    int pend[$];
    int order[$];
    int exp_ord[3];
    exp_ord = '{1, 2, 4};
    vec = '{'{32'd3, 3, 292, 355}, '{32'd35, 3, 292, 355}, '{32'd0, 0, 100, 163},
            '{32'd31, 31, 2084, 2147}, '{32'd63, 31, 2084, 2147},
            '{32'hFFFF_FFE1, 1, 164, 227}, '{32'd17, 17, 1188, 1251}};
    reset = 1; req_valid = 1; req_block = 3;
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_out_index", out_index, 0);
    bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (out_block[r][c] !== DATA_W'(1)) bad++;
    check("rst_out_block_errors", bad, 0);
    reset = 0; req_valid = 0;
    #1 check("ready_after_reset", req_ready, 1);
    @(negedge clock);

    foreach (vec[i]) begin
      req_valid = 1; req_block = vec[i].blk;
      cycle(acc);
      req_valid = 0; n = 0;
      while (!out_valid && n < 3 * PIX) begin cycle(acc); n++; end
      check("latency", n, PIX);
      check("vec_index", out_index, vec[i].idx);
      check("vec_b00", out_block[0][0], vec[i].b00);
      check("vec_b77", out_block[ROWS-1][COLS-1], vec[i].b77);
      out_ready = 1; cycle(acc); out_ready = 0;
    end

    pend = '{1, 2, 4};
    for (int k = 0; k < 2 * PIX + 12; k++) begin
      req_valid = pend.size() > 0;
      if (pend.size() > 0) req_block = pend[0];
      cycle(acc);
      if (acc) void'(pend.pop_front());
    end
    check("held_requests", pend.size(), 1);
    check("both_full_ready", req_ready, 0);
    for (int k = 0; k < 3 * PIX; k++) begin
      req_valid = pend.size() > 0;
      if (pend.size() > 0) req_block = pend[0];
      out_ready = k == 0 || k >= PIX + 10;
      if (k == 1) check("ready_after_pop", req_ready, 1);
      if (out_valid && out_ready) order.push_back(int'(out_index));
      cycle(acc);
      if (acc) void'(pend.pop_front());
    end
    req_valid = 0; out_ready = 0;
    check("order_len", order.size(), 3);
    for (int k = 0; k < 3; k++) check("order", k < order.size() ? order[k] : -1, exp_ord[k]);

    pend = '{5, 6};
    for (int k = 0; k < 2 * PIX + 10; k++) begin
      req_valid = pend.size() > 0;
      if (pend.size() > 0) req_block = pend[0];
      out_ready = fetching && t == 1 && q.size() == 1;
      cycle(acc);
      if (acc) void'(pend.pop_front());
    end
    req_valid = 0; out_ready = 0;
    check("swap_valid", out_valid, 1);
    check("swap_index", out_index, 6);
    out_ready = 1; cycle(acc); cycle(acc); out_ready = 0;

    req_valid = 1; req_block = 9;
    cycle(acc);
    req_valid = 0; n = 0;
    while (mem_rd_addr != ADDR_W'(9 * PIX + 30) && n < PIX) begin cycle(acc); n++; end
    check("reach_elem30", mem_rd_addr, 9 * PIX + 30);
    reset = 1;
    @(negedge clock);
    reset = 0; fetching = 0; q.delete();
    #1 check("abort_mem_rd_en", mem_rd_en, 0);
    check("abort_out_valid", out_valid, 0);
    @(negedge clock);
    repeat (PIX + 4) cycle(acc);
    req_valid = 1; req_block = 10;
    cycle(acc);
    req_valid = 0; n = 0;
    while (!out_valid && n < 3 * PIX) begin cycle(acc); n++; end
    check("refill_latency", n, PIX);
    check("refill_b00", out_block[0][0], 10 * PIX + 100);
    out_ready = 1; cycle(acc); out_ready = 0;

    for (int k = 0; k < 800; k++) begin
      req_valid = $urandom_range(0, 1) == 1;
      req_block = $urandom;
      out_ready = $urandom_range(0, 3) == 0;
      cycle(acc);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
